// File: rtl/spike_decoder_pkg.sv
// spike_decoder_pkg: shared types and constants for the spike decoder.
//   state_t        - decoder FSM states (IDLE, COLLECT, SCAN, DONE)
//   calc_window()  - encoding window length in clk cycles
//   LABEL_W        - width of one class label nibble
//   NO_SPIKE_LABEL - label reported when no neuron fired
package spike_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int LABEL_W = 4;
  localparam logic [LABEL_W-1:0] NO_SPIKE_LABEL = 4'hF;

  // One window spans T_WINDOW encoded slots, each followed by ENCODE_TIME idle slots.
  function automatic int calc_window(input int t_window, input int encode_time);
    return t_window * (encode_time + 1);
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// spike_counter_sat: one saturating per-neuron spike counter.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   en       - global enable; counter holds when low
//   clr      - clear to zero (takes priority over inc)
//   inc      - add one, sticking at the all-ones value
//   cnt      - current count
module spike_counter_sat
  import spike_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// spike_decoder: counts the out_spike lines of N_NEURON excitatory neurons
// over one encoding window, then scans the counts for the argmax neuron.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en           - global enable; all state freezes when low
//   start        - begin a decode (accepted in IDLE only)
//   in_spikes    - one spike bit per neuron, bit i = neuron i
//   busy         - high while collecting or scanning
//   done         - high for the single DONE cycle (stretches while en is low)
//   winner_idx   - index of the highest-count neuron (ties -> lowest index)
//   winner_cnt   - count of the winning neuron
//   no_spike     - all counts were zero in the last decode
// Optional (macro SPIKE_DECODER_LABEL_EN):
//   label_map    - nibble i is the class label of neuron i
//   winner_label - label of the winner, NO_SPIKE_LABEL when nothing fired
module spike_decoder
  import spike_decoder_pkg::*;
#(
  parameter int N_NEURON    = 100,
  parameter int ENCODE_TIME = 23,
  parameter int T_WINDOW    = 250,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [N_NEURON-1:0]   in_spikes,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      winner_idx,
  output logic [CNT_W-1:0]      winner_cnt,
  output logic                  no_spike
`ifdef SPIKE_DECODER_LABEL_EN
  ,
  input  logic [N_NEURON*4-1:0] label_map,
  output logic [LABEL_W-1:0]    winner_label
`endif
);

  localparam int WIN   = calc_window(T_WINDOW, ENCODE_TIME);
  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURON - 1);

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   win_cnt;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   best_idx;
  logic [CNT_W-1:0]   best_cnt;
  logic [IDX_W-1:0]   nxt_best_idx;
  logic [CNT_W-1:0]   nxt_best_cnt;
  logic [CNT_W-1:0]   cand_cnt;
  logic [CNT_W-1:0]   cnt_arr [N_NEURON];
  logic               start_acc;
  logic               collect;
  logic               win_last;
  logic               scan_last;

  assign start_acc = (state == IDLE) && start;
  assign collect   = (state == COLLECT);
  assign win_last  = (win_cnt == WIN_LAST);
  assign scan_last = (scan_idx == IDX_LAST);

  // Collect: per-neuron saturating counters, cleared on an accepted start.
  for (genvar i = 0; i < N_NEURON; i++) begin : g_cnt
    spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (start_acc),
      .inc (collect && in_spikes[i]),
      .cnt (cnt_arr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (en && start) state_nxt = COLLECT;
      COLLECT: begin
        busy = 1'b1;
        if (en && win_last) state_nxt = SCAN;
      end
      SCAN:    begin
        busy = 1'b1;
        if (en && scan_last) state_nxt = DONE;
      end
      DONE:    begin
        done = 1'b1;
        if (en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan: index 0 seeds the running best; later indices replace it only on
  // strictly greater counts, so ties keep the lowest index.
  always_comb begin
    cand_cnt     = cnt_arr[scan_idx];
    nxt_best_idx = best_idx;
    nxt_best_cnt = best_cnt;
    if ((scan_idx == '0) || (cand_cnt > best_cnt)) begin
      nxt_best_idx = scan_idx;
      nxt_best_cnt = cand_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (en && (state == SCAN)) begin
      best_idx <= nxt_best_idx;
      best_cnt <= nxt_best_cnt;
    end
  end

  // Result: loaded on the last scan step so it is valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      scan_idx     <= '0;
      winner_idx   <= '0;
      winner_cnt   <= '0;
      no_spike     <= 1'b0;
`ifdef SPIKE_DECODER_LABEL_EN
      winner_label <= '0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            win_cnt  <= '0;
            scan_idx <= '0;
          end
        end
        COLLECT: win_cnt <= win_cnt + 1'b1;
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (scan_last) begin
            winner_idx   <= nxt_best_idx;
            winner_cnt   <= nxt_best_cnt;
            no_spike     <= (nxt_best_cnt == '0);
`ifdef SPIKE_DECODER_LABEL_EN
            winner_label <= (nxt_best_cnt == '0) ? NO_SPIKE_LABEL
                          : label_map[nxt_best_idx*LABEL_W +: LABEL_W];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder: directed-vector bench for spike_decoder with
// N_NEURON=4, ENCODE_TIME=1, T_WINDOW=4 (window of 8 cycles), CNT_W=3.
// Optional label outputs are exercised when SPIKE_DECODER_LABEL_EN is defined.
module tb_spike_decoder;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic          start;
  logic [N-1:0]  in_spikes;
  logic          busy;
  logic          done;
  logic [IW-1:0] winner_idx;
  logic [CW-1:0] winner_cnt;
  logic          no_spike;
`ifdef SPIKE_DECODER_LABEL_EN
  logic [N*4-1:0] label_map;
  logic [3:0]     winner_label;
`endif

  int n_chk = 0;
  int n_err = 0;

  spike_decoder #(
    .N_NEURON    (N),
    .ENCODE_TIME (1),
    .T_WINDOW    (4),
    .CNT_W       (CW),
    .IDX_W       (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (start),
    .in_spikes    (in_spikes),
    .busy         (busy),
    .done         (done),
    .winner_idx   (winner_idx),
    .winner_cnt   (winner_cnt),
    .no_spike     (no_spike)
`ifdef SPIKE_DECODER_LABEL_EN
    ,
    .label_map    (label_map),
    .winner_label (winner_label)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue start, then drive nibble k of pat as in_spikes on window cycle k.
  // en is dropped for freeze_len cycles from cycle freeze_at; start is
  // re-pulsed on cycle restart_at. Returns done latency in cycles after the
  // start edge (-1 if no done within budget), done pulse count, busy cycles.
  task automatic run_decode(input logic [31:0] pat, input logic [3:0] start_spk,
                            input int restart_at, input int freeze_at, input int freeze_len,
                            output int lat, output int n_done, output int busy_cyc);
    int   k;
    logic prev_done;
    lat       = -1;
    n_done    = 0;
    busy_cyc  = 0;
    k         = 0;
    prev_done = 1'b0;
    en        = 1'b1;
    start     = 1'b1;
    in_spikes = start_spk;
    tick;
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done && !prev_done) begin
        n_done++;
        if (lat < 0) lat = c;
      end
      prev_done = done;
      if (busy) busy_cyc++;
      if ((lat >= 0) && (c >= lat + 3)) break;
      en        = !((c >= freeze_at) && (c < freeze_at + freeze_len));
      in_spikes = (k < 8) ? pat[k*4 +: 4] : 4'h0;
      start     = (c == restart_at);
      tick;
      if (en) k++;
    end
    en        = 1'b1;
    start     = 1'b0;
    in_spikes = '0;
  endtask

  int lat, nd, bc;

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    start     = 1'b0;
    in_spikes = '0;
`ifdef SPIKE_DECODER_LABEL_EN
    label_map = 16'h9765;
`endif
    tick;
    tick;
    rst = 1'b0;
    tick;

    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_idx", winner_idx, 0);
    chk("reset_cnt", winner_cnt, 0);
    chk("reset_nospike", no_spike, 0);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("reset_label", winner_label, 0);
`endif

    // Neuron 2 fires on three window cycles.
    run_decode(32'h0040_4040, 4'h0, -1, 99, 0, lat, nd, bc);
    chk("t1_latency", lat, 12);
    chk("t1_busy_cycles", bc, 12);
    chk("t1_done_pulses", nd, 1);
    chk("t1_idx", winner_idx, 2);
    chk("t1_cnt", winner_cnt, 3);
    chk("t1_nospike", no_spike, 0);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("t1_label", winner_label, 4'h7);
`endif

    // Neurons 1 and 3 tie at five spikes.
    run_decode(32'h000A_AAAA, 4'h0, -1, 99, 0, lat, nd, bc);
    chk("t2_idx", winner_idx, 1);
    chk("t2_cnt", winner_cnt, 5);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("t2_label", winner_label, 4'h6);
`endif

    // Neuron 0 fires every cycle: 8 spikes saturate a 3-bit counter at 7.
    run_decode(32'h1111_1111, 4'h0, -1, 99, 0, lat, nd, bc);
    chk("t3_idx", winner_idx, 0);
    chk("t3_cnt_sat", winner_cnt, 7);

    // Silence.
    run_decode(32'h0000_0000, 4'h0, -1, 99, 0, lat, nd, bc);
    chk("t4_idx", winner_idx, 0);
    chk("t4_cnt", winner_cnt, 0);
    chk("t4_nospike", no_spike, 1);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("t4_label", winner_label, 4'hF);
`endif

    // Spike on the start cycle (neuron 3) and start re-pulsed mid-collect.
    run_decode(32'h0000_0202, 4'h8, 3, 99, 0, lat, nd, bc);
    chk("t5_done_pulses", nd, 1);
    chk("t5_latency", lat, 12);
    chk("t5_idx", winner_idx, 1);
    chk("t5_cnt", winner_cnt, 2);
    chk("t5_nospike", no_spike, 0);

    // Reset mid-collect: immediate abort, outputs cleared, no done afterwards.
    en        = 1'b1;
    start     = 1'b1;
    in_spikes = 4'hF;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_spikes = '0;
    chk("t6_busy", busy, 0);
    chk("t6_idx", winner_idx, 0);
    chk("t6_cnt", winner_cnt, 0);
    chk("t6_nospike", no_spike, 0);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("t6_label", winner_label, 0);
`endif
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) nd++;
      tick;
    end
    chk("t6_no_done", nd, 0);

    // en low for 5 cycles mid-collect: done slips by exactly 5 cycles.
    run_decode(32'h0000_8888, 4'h0, -1, 3, 5, lat, nd, bc);
    chk("t7_latency", lat, 17);
    chk("t7_done_pulses", nd, 1);
    chk("t7_idx", winner_idx, 3);
    chk("t7_cnt", winner_cnt, 4);
`ifdef SPIKE_DECODER_LABEL_EN
    chk("t7_label", winner_label, 4'h9);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spike_decoder.md
Name: spike_decoder

Overview:
- Output-side counterpart of the input spike encoder. It collects the 1-bit out_spike lines of N excitatory neurons over one encoding window of T_WINDOW*(ENCODE_TIME+1) cycles.
- It keeps a saturating spike count per neuron, then scans the counts sequentially to find the winning neuron (argmax).
- Sits after the excitatory layer; its result feeds classification/readout logic.

Parameters:
- N_NEURON, 100, number of excitatory neurons observed
- ENCODE_TIME, 23, idle slots between encoded input slots (matches encoder)
- T_WINDOW, 250, input slots per sample; window W = T_WINDOW*(ENCODE_TIME+1) cycles
- CNT_W, 8, per-neuron spike counter width (saturating)
- IDX_W, 7, neuron index width; ceil(log2(N_NEURON)) minimum

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  global enable; when low, all state and counters freeze
- start  in  1  begin a decode; accepted only in IDLE with en=1
- in_spikes  in  N_NEURON  out_spike bit of each excitatory neuron, bit i = neuron i
- busy  out  1  high in COLLECT and SCAN
- done  out  1  one-cycle pulse when the result becomes valid
- winner_idx  out  IDX_W  index of the neuron with the highest count
- winner_cnt  out  CNT_W  count of the winning neuron
- no_spike  out  1  high when all counts were zero in the last decode

Behaviour:
- Reset: state=IDLE, all counters=0, busy=0, done=0, winner_idx=0, winner_cnt=0, no_spike=0. Reset mid-operation aborts immediately with no done pulse.
- FSM IDLE->COLLECT->SCAN->DONE->IDLE. Every transition and counter update is qualified by en=1.
- IDLE:
  - start=1 clears all per-neuron counters and the window counter, then moves to COLLECT next cycle.
  - in_spikes are ignored in IDLE, including on the start cycle.
- COLLECT:
  - Each en cycle, counter[i] += in_spikes[i]; the counter saturates at 2^CNT_W-1 and never wraps.
  - The window counter runs 0..W-1. On the cycle it equals W-1, spikes are still counted, then state goes to SCAN. Exactly W spike-sampling cycles per decode.
- SCAN:
  - One neuron per en cycle, index 0..N_NEURON-1, compared against a running best with strict greater-than. Ties therefore resolve to the lowest index.
  - Running best initialises to idx 0, cnt counter[0].
  - After index N_NEURON-1 the state goes to DONE.
- DONE (1 cycle):
  - winner_idx, winner_cnt and no_spike (= winner_cnt==0) are registered.
  - done=1 for this cycle only, then IDLE.
  - Outputs hold until the next DONE or reset.
- Latency: start accepted at cycle t -> done at t+W+N_NEURON+1, with en held high.
- start while busy or in DONE: ignored, with no queueing.
- en low: freezes in place and no sample is taken. The window length counts en cycles, not clk cycles. A done pulse stretches while en is low.
- All spikes are in the single clk domain; there is no synchroniser.

Optional Feature:
- Macro SPIKE_DECODER_LABEL_EN.
- Defined:
  - Adds input label_map [N_NEURON*4-1:0], where nibble i is the class label of neuron i.
  - Adds output winner_label [3:0], registered in DONE as label_map nibble winner_idx.
  - winner_label resets to 0. When no_spike=1, winner_label=4'hF.
- Undefined: neither port exists and there is no label logic.

Decomposition:
- Package spike_decoder_pkg:
  - FSM state enum (IDLE, COLLECT, SCAN, DONE)
  - function computing W from T_WINDOW and ENCODE_TIME
  - label-width constant (4) and no-spike label 4'hF
- Sub-module spike_counter_sat: one CNT_W saturating counter with clr, inc and en, instantiated N_NEURON times via generate.

Test Plan (N_NEURON=4, ENCODE_TIME=1, T_WINDOW=4, so W=8, CNT_W=3):
- Reset then start. in_spikes=4'b0100 on 3 window cycles -> done at t+13 with winner_idx=2, winner_cnt=3, no_spike=0; busy high for cycles t+1..t+12.
- Neurons 1 and 3 each spike 5 times -> winner_idx=1 (lowest-index tie), winner_cnt=5.
- Neuron 0 spikes on all 8 cycles -> counter saturates, winner_cnt=7 (no wrap), winner_idx=0.
- No spikes -> winner_idx=0, winner_cnt=0, no_spike=1; with SPIKE_DECODER_LABEL_EN, winner_label=4'hF.
- Spikes on the start cycle and start re-asserted during COLLECT -> neither affects the result; exactly one done pulse.
- rst asserted mid-COLLECT, then en low for 5 cycles during a second run -> first run gives no done and outputs reset to 0; second run's done is delayed by exactly 5 cycles.
